// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for alu_seq.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
   localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
   localparam logic [OP_W-1:0] OP_MFHI  = 4'b0100;
   localparam logic [OP_W-1:0] OP_MFLO  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
   localparam logic [OP_W-1:0] OP_SLTU  = 4'b1000;
   localparam logic [OP_W-1:0] OP_SLL   = 4'b1001;
   localparam logic [OP_W-1:0] OP_SRL   = 4'b1010;
   localparam logic [OP_W-1:0] OP_SRA   = 4'b1011;
   localparam logic [OP_W-1:0] OP_NOR   = 4'b1100;
   localparam logic [OP_W-1:0] OP_MULTU = 4'b1101;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'b1110;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   function automatic logic is_multicycle(input logic [OP_W-1:0] op);
      return (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per cycle.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]     opnd;
   logic                 mode_div;
   logic                 run;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_rem;
   logic [WIDTH+1:0]     div_diff;

   // One iteration; acc upper half is product-high / partial remainder,
   // lower half is multiplier / dividend-then-quotient.
   always_comb begin
      acc_nxt  = acc;
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]};
      div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = {1'b0, div_rem} - {2'b00, opnd};
      if (acc[0]) begin
         mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      end
      if (mode_div) begin
         if (!div_diff[WIDTH+1]) begin
            acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   assign done   = run && (cnt == CW'(WIDTH - 1));
   assign hi_out = acc_nxt[2*WIDTH-1:WIDTH];
   assign lo_out = acc_nxt[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         mode_div <= 1'b0;
         run      <= 1'b0;
      end else if (start) begin
         cnt      <= '0;
         acc      <= {{WIDTH{1'b0}}, a};
         opnd     <= b;
         mode_div <= (op == OP_DIVU);
         run      <= 1'b1;
      end else if (run) begin
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         if (done) begin
            run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops complete next cycle, MULTU/DIVU run iteratively into HI/LO.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  alu_ctrl,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_e           state, state_d;
   logic             accept;
   logic             start;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum, diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             md_done;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic             valid_d, zero_d, ovf_d;
   logic [WIDTH-1:0] result_d, hi_d, lo_d;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign start    = accept && is_multicycle(alu_ctrl);
   assign shamt    = b[SHW-1:0];
   assign sum      = a + b;
   assign diff     = a - b;

   // Single-cycle operation set
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alu_ctrl)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (alu_ctrl),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .hi_out (md_hi),
      .lo_out (md_lo)
   );

   // Next state and next registered outputs
   always_comb begin
      state_d  = state;
      valid_d  = 1'b0;
      result_d = result;
      zero_d   = zero;
      ovf_d    = overflow;
      hi_d     = hi;
      lo_d     = lo;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_multicycle(alu_ctrl)) begin
                  state_d = S_BUSY;
               end else begin
                  valid_d  = 1'b1;
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  ovf_d    = alu_ovf;
               end
            end
         end
         S_BUSY: begin
            if (md_done) begin
               state_d  = S_IDLE;
               valid_d  = 1'b1;
               hi_d     = md_hi;
               lo_d     = md_lo;
               result_d = md_lo;
               zero_d   = (md_lo == '0);
               ovf_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         state     <= state_d;
         out_valid <= valid_d;
         result    <= result_d;
         zero      <= zero_d;
         overflow  <= ovf_d;
         hi        <= hi_d;
         lo        <= lo_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] res;
      logic         ovf;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic [3:0]   alu_ctrl;
   logic         out_valid;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .alu_ctrl  (alu_ctrl),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .hi        (hi),
      .lo        (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
      in_valid = 1'b1;
      alu_ctrl = op;
      a        = va;
      b        = vb;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0)
         begin errors++; $display("FAIL reset_result got %h/%b/%b exp 0/1/0", result, zero, overflow); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add_overflow;
      drive(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
      checks++; if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0)
         begin errors++; $display("FAIL add_ovf got %h/%b/%b exp 80000000/1/0", result, overflow, zero); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || result !== 32'h8000_0000)
         begin errors++; $display("FAIL add_hold got %b/%h exp 0/80000000", out_valid, result); end
   endtask

   task automatic test_sub_zero;
      drive(OP_SUB, 32'd5, 32'd5);
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0)
         begin errors++; $display("FAIL sub_zero got %b/%h/%b/%b exp 1/0/1/0", out_valid, result, zero, overflow); end
      @(negedge clk);
   endtask

   // Stream a table of single-cycle ops one per cycle, checking each the cycle after accept
   task automatic run_table(input vec_t tbl[], input string tag);
      for (int i = 0; i <= tbl.size(); i++) begin
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || result !== tbl[i-1].res || overflow !== tbl[i-1].ovf
                || zero !== (tbl[i-1].res == '0)) begin
               errors++;
               $display("FAIL %s[%0d] op %b got v%b %h z%b o%b exp v1 %h o%b", tag, i-1, tbl[i-1].op,
                        out_valid, result, zero, overflow, tbl[i-1].res, tbl[i-1].ovf);
            end
         end
         if (i < tbl.size()) drive(tbl[i].op, tbl[i].va, tbl[i].vb);
         else in_valid = 1'b0;
         @(negedge clk);
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_end_valid got %b exp 0", tag, out_valid); end
   endtask

   task automatic test_back_to_back;
      vec_t tbl[];
      tbl = new[3];
      tbl[0] = '{OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0};
      tbl[1] = '{OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0};
      tbl[2] = '{OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0};
      run_table(tbl, "b2b");
   endtask

   task automatic test_compare_shift;
      vec_t tbl[];
      tbl = new[10];
      tbl[0] = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
      tbl[1] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
      tbl[2] = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
      tbl[3] = '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0};
      tbl[4] = '{OP_SLL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0};
      tbl[5] = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
      tbl[6] = '{OP_ADD,  32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0};
      tbl[7] = '{OP_OR,   32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0};
      tbl[8] = '{4'b1111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
      tbl[9] = '{OP_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
      run_table(tbl, "ops");
   endtask

   task automatic test_multu;
      int busy_bad = 0;
      drive(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
      @(negedge clk);
      drive(OP_AND, 32'h1, 32'h1);
      for (int i = 1; i <= 32; i++) begin
         if (i > 1) @(negedge clk);
         if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
         if (i == 32) begin
            checks++; if (hi !== 32'h0 || lo !== 32'h0)
               begin errors++; $display("FAIL multu_hilo_early got %h/%h exp 0/0", hi, lo); end
         end
      end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL multu_busy got %0d bad cycles exp 0", busy_bad); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1)
         begin errors++; $display("FAIL multu_done got v%b r%b exp v1 r1", out_valid, in_ready); end
      checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE || result !== 32'hFFFF_FFFE || zero !== 1'b0)
         begin errors++; $display("FAIL multu_value got %h/%h/%h exp 1/fffffffe/fffffffe", hi, lo, result); end
      drive(OP_MFHI, 32'h0, 32'h0);
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 32'h1)
         begin errors++; $display("FAIL mfhi_after got v%b %h exp v1 1", out_valid, result); end
      @(negedge clk);
   endtask

   task automatic test_divu;
      int n;
      drive(OP_DIVU, 32'd100, 32'd7);
      @(negedge clk); in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (n != 33) begin errors++; $display("FAIL divu_latency got %0d exp 33", n); end
      checks++; if (lo !== 32'd14 || hi !== 32'd2 || result !== 32'd14)
         begin errors++; $display("FAIL divu_value got lo %h hi %h res %h exp e/2/e", lo, hi, result); end
      @(negedge clk);
      drive(OP_DIVU, 32'd9, 32'd0);
      @(negedge clk); in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (n != 33) begin errors++; $display("FAIL divz_latency got %0d exp 33", n); end
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd9)
         begin errors++; $display("FAIL divz_value got lo %h hi %h exp ffffffff/9", lo, hi); end
      drive(OP_MFLO, 32'h0, 32'h0);
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF)
         begin errors++; $display("FAIL mflo_after got v%b %h exp v1 ffffffff", out_valid, result); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int stray = 0;
      drive(OP_MULTU, 32'd3, 32'd5);
      @(negedge clk); in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (hi !== 32'h0 || lo !== 32'h0)
         begin errors++; $display("FAIL rstmid_hilo got %h/%h exp 0/0", hi, lo); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0)
         begin errors++; $display("FAIL rstmid_outs got r%b v%b %h z%b o%b exp 1/0/0/1/0",
                                  in_ready, out_valid, result, zero, overflow); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_stray got %0d cycles exp 0", stray); end
      drive(OP_ADD, 32'd2, 32'd3);
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 32'd5 || hi !== 32'h0)
         begin errors++; $display("FAIL rstmid_add got v%b %h hi %h exp v1 5 hi 0", out_valid, result, hi); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_zero();
      test_back_to_back();
      test_compare_shift();
      test_multu();
      test_divu();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
